ifu_predecode_bp: RTL

- Registered successor to the IFU predecode: decodes one fetched instruction per cycle for jump class (JAL, JALR, Bxx) and extracts rs1/rs2/rd plus the sign-extended immediate.
- Adds static prediction (JAL always taken, Bxx backward-taken/forward-not-taken) and a parametrised return-address stack (RAS) for JALR returns.
- Sits between the fetch buffer and the IFU PC mux; a valid/ready handshake on both sides gives one pipeline stage.

---
 rtl/ifu_pkg.sv | 60 ++++++
 rtl/ifu_ras.sv | 50 +++++
 rtl/ifu_predecode_bp.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// IFU predecode shared types and constants.
// Opcodes, link registers and the combinational jump-class decoder.
package ifu_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [4:0] REG_RA = 5'd1;
    localparam logic [4:0] REG_T0 = 5'd5;

    // Decoded immediates never exceed 32 bits; the top sign-extends to XLEN.
    localparam int IMM_W = 32;

    typedef struct packed {
        logic             op_jal;
        logic             op_jalr;
        logic             op_bxx;
        logic [IMM_W-1:0] imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
    } predecode_t;

    function automatic logic is_link(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction

    function automatic predecode_t predecode(input logic [31:0] inst);
        predecode_t pd;
        logic [2:0] f3;
        f3 = inst[14:12];
        pd = '0;
        pd.op_jal  = (inst[6:0] == OPC_JAL);
        pd.op_jalr = (inst[6:0] == OPC_JALR) && (f3 == 3'b000);
        pd.op_bxx  = (inst[6:0] == OPC_BRANCH) &&
                     (f3 != 3'b010) && (f3 != 3'b011);
        unique case (1'b1)
            pd.op_jal: begin
                pd.imm = {{11{inst[31]}}, inst[31], inst[19:12],
                          inst[20], inst[30:21], 1'b0};
                pd.rd  = inst[11:7];
            end
            pd.op_jalr: begin
                pd.imm = {{20{inst[31]}}, inst[31:20]};
                pd.rs1 = inst[19:15];
                pd.rd  = inst[11:7];
            end
            pd.op_bxx: begin
                pd.imm = {{19{inst[31]}}, inst[31], inst[7],
                          inst[30:25], inst[11:8], 1'b0};
                pd.rs1 = inst[19:15];
                pd.rs2 = inst[24:20];
            end
            default: ;
        endcase
        return pd;
    endfunction

endpackage

// File: rtl/ifu_ras.sv
// Circular return-address stack.
// Full pushes overwrite the oldest entry; push+pop replaces the top.
module ifu_ras
    import ifu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4,
    parameter int RAS_PTR_W = $clog2(RAS_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    logic [XLEN-1:0]    mem [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ptr;
    logic [RAS_PTR_W:0]   cnt;
    logic [RAS_PTR_W-1:0] top_idx;

    assign top_idx = ptr - RAS_PTR_W'(1);
    assign top     = mem[top_idx];
    assign empty   = (cnt == '0);

    // Pointer, count and entry updates; popping an empty stack is a no-op.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && pop && !empty) begin
            mem[top_idx] <= push_data;
        end else if (push) begin
            mem[ptr] <= push_data;
            ptr      <= ptr + RAS_PTR_W'(1);
            if (cnt != (RAS_PTR_W+1)'(RAS_DEPTH)) begin
                cnt <= cnt + (RAS_PTR_W+1)'(1);
            end
        end else if (pop && !empty) begin
            ptr <= top_idx;
            cnt <= cnt - (RAS_PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/ifu_predecode_bp.sv
// Registered IFU predecode with static branch prediction and RAS.
// One valid/ready pipeline stage between fetch buffer and PC mux.
module ifu_predecode_bp
    import ifu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4,
    parameter int RAS_PTR_W = $clog2(RAS_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_inst,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [31:0]     o_inst,
    output logic            o_op_jal,
    output logic            o_op_jalr,
    output logic            o_op_bxx,
    output logic [XLEN-1:0] o_jump_imm,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_pc,
    output logic            o_ras_hit
);

    predecode_t      pd;
    logic [XLEN-1:0] imm_x;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;
    logic            push_req;
    logic            pop_req;
    logic            accept;
    logic            upd;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            pred_taken;
    logic [XLEN-1:0] pred_pc;
    logic            ras_hit;

    assign pd          = predecode(i_inst);
    assign imm_x       = XLEN'($signed(pd.imm));
    assign pc_plus4    = i_pc + XLEN'(4);
    assign pc_plus_imm = i_pc + imm_x;

    assign push_req = (pd.op_jal || pd.op_jalr) && is_link(pd.rd);
    assign pop_req  = pd.op_jalr && is_link(pd.rs1) && (pd.rs1 != pd.rd);

    assign i_ready = !o_valid || o_ready;
    assign accept  = i_valid && i_ready;
    assign upd     = accept && !flush;

    ifu_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH),
        .RAS_PTR_W (RAS_PTR_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (upd && push_req),
        .pop       (upd && pop_req),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    // Static prediction from the incoming instruction and current RAS top.
    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = pc_plus4;
        ras_hit    = 1'b0;
        unique case (1'b1)
            pd.op_jal: begin
                pred_taken = 1'b1;
                pred_pc    = pc_plus_imm;
            end
            pd.op_bxx: begin
                pred_taken = imm_x[XLEN-1];
                pred_pc    = imm_x[XLEN-1] ? pc_plus_imm : pc_plus4;
            end
            pd.op_jalr: begin
                if (pop_req && !ras_empty) begin
                    pred_taken = 1'b1;
                    pred_pc    = ras_top;
                    ras_hit    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output stage: load on accept, drain on ready, drop on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid      <= 1'b0;
            o_pc         <= '0;
            o_inst       <= '0;
            o_op_jal     <= 1'b0;
            o_op_jalr    <= 1'b0;
            o_op_bxx     <= 1'b0;
            o_jump_imm   <= '0;
            o_rs1        <= '0;
            o_rs2        <= '0;
            o_rd         <= '0;
            o_pred_taken <= 1'b0;
            o_pred_pc    <= '0;
            o_ras_hit    <= 1'b0;
        end else if (flush) begin
            o_valid <= 1'b0;
        end else if (accept) begin
            o_valid      <= 1'b1;
            o_pc         <= i_pc;
            o_inst       <= i_inst;
            o_op_jal     <= pd.op_jal;
            o_op_jalr    <= pd.op_jalr;
            o_op_bxx     <= pd.op_bxx;
            o_jump_imm   <= imm_x;
            o_rs1        <= pd.rs1;
            o_rs2        <= pd.rs2;
            o_rd         <= pd.rd;
            o_pred_taken <= pred_taken;
            o_pred_pc    <= pred_pc;
            o_ras_hit    <= ras_hit;
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule
